// File: rtl/seq_divider_1x.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_1x
// Purpose  : Sequential signed divider producing one quotient bit per cycle.
//            An unsigned restoring core runs on operand magnitudes. A single
//            fix-up cycle then applies the signs and handles the
//            divide-by-zero and overflow corner cases.
// Ports    : Clk     - system clock, rising edge
//            Rst     - synchronous active-high reset
//            Ld      - load X/D and start (aborts any division in flight)
//            X, D    - signed dividend / divisor, N bits
//            Busy    - division in progress (ITER or FIX)
//            Valid   - one-cycle pulse after Q/Rm/flags update
//            Q, Rm   - signed quotient (toward zero) / remainder (sign of X)
//            DivZero - last result had D == 0
//            Ovf     - last result was X = -2^(N-1), D = -1
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_1x #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Ld,
    input  logic [N-1:0] X,
    input  logic [N-1:0] D,
    output logic         Busy,
    output logic         Valid,
    output logic [N-1:0] Q,
    output logic [N-1:0] Rm,
    output logic         DivZero,
    output logic         Ovf
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [N-1:0]   quo_q,   quo_d;    // |X| shifts out, quotient bits shift in
    logic [N-1:0]   rem_q,   rem_d;    // partial remainder magnitude
    logic [N:0]     dmag_q,  dmag_d;   // |D|, N+1 bits so 2^(N-1) is exact
    logic [N-1:0]   x_q,     x_d;      // original operands, for signs and flags
    logic [N-1:0]   dv_q,    dv_d;
    logic [N-1:0]   q_q,     q_d;
    logic [N-1:0]   rm_q,    rm_d;
    logic           dz_q,    dz_d;
    logic           ovf_q,   ovf_d;
    logic           valid_q, valid_d;

    logic [N-1:0]   w_xmag;
    logic [N:0]     w_dext;
    logic [N:0]     w_dmag;
    logic [N:0]     w_shift;
    logic [N+1:0]   w_sub;
    logic           w_fits;
    logic           w_qneg;
    logic [N-1:0]   w_qfix;
    logic [N-1:0]   w_rfix;
    logic           w_dzero;
    logic           w_ovf;

    // Operand magnitudes. -(-2^(N-1)) wraps to 2^(N-1), which is exactly the
    // right unsigned magnitude in N bits; the divisor uses N+1 bits.
    assign w_xmag = X[N-1] ? (-X) : X;
    assign w_dext = {D[N-1], D};
    assign w_dmag = D[N-1] ? (-w_dext) : w_dext;

    // Restoring step: bring down the next dividend bit and trial-subtract.
    // The remainder stays below |D| <= 2^(N-1), so the shifted value is below
    // 2^N; a valid (non-negative) difference therefore has both top bits clear.
    assign w_shift = {rem_q, quo_q[N-1]};
    assign w_sub   = {1'b0, w_shift} - {1'b0, dmag_q};
    assign w_fits  = ~w_sub[N+1] & ~w_sub[N];

    // Sign correction applied in the FIX cycle.
    assign w_qneg  = x_q[N-1] ^ dv_q[N-1];
    assign w_qfix  = w_qneg ? (-quo_q) : quo_q;
    assign w_rfix  = x_q[N-1] ? (-rem_q) : rem_q;
    assign w_dzero = (dv_q == '0);
    assign w_ovf   = (x_q == {1'b1, {(N-1){1'b0}}}) && (dv_q == '1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dmag_d  = dmag_q;
        x_d     = x_q;
        dv_d    = dv_q;
        q_d     = q_q;
        rm_d    = rm_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_ITER: begin
                quo_d = {quo_q[N-2:0], w_fits};
                rem_d = w_fits ? w_sub[N-1:0] : w_shift[N-1:0];
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                // Divide-by-zero overrides whatever the core produced; the
                // overflow case already wraps naturally, only the flag is set.
                if (w_dzero) begin
                    q_d  = '1;
                    rm_d = x_q;
                end else begin
                    q_d  = w_qfix;
                    rm_d = w_rfix;
                end
                dz_d    = w_dzero;
                ovf_d   = w_ovf;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load restarts from any state. In FIX the result assignments above
        // are left intact, so that result still completes at this edge.
        if (Ld) begin
            state_d = S_ITER;
            cnt_d   = CW'(N - 1);
            quo_d   = w_xmag;
            rem_d   = '0;
            dmag_d  = w_dmag;
            x_d     = X;
            dv_d    = D;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dmag_q  <= '0;
            x_q     <= '0;
            dv_q    <= '0;
            q_q     <= '0;
            rm_q    <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dmag_q  <= dmag_d;
            x_q     <= x_d;
            dv_q    <= dv_d;
            q_q     <= q_d;
            rm_q    <= rm_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign Valid   = valid_q;
    assign Q       = q_q;
    assign Rm      = rm_q;
    assign DivZero = dz_q;
    assign Ovf     = ovf_q;

endmodule
`default_nettype wire

// File: doc/seq_divider_1x.md
SEQ_DIVIDER_1X -- requirements
Module: seq_divider_1x

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..16.
REQ-002 Clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 Rst  input  1  reset; synchronous, active-high.
REQ-004 Ld  input  1  load operands and start a division.
REQ-005 X  input  N  dividend, signed two's complement.
REQ-006 D  input  N  divisor, signed two's complement.
REQ-007 Busy  output  1  division in progress.
REQ-008 Valid  output  1  one-cycle pulse: Q, Rm and flags are updated.
REQ-009 Q  output  N  quotient, signed.
REQ-010 Rm  output  N  remainder, signed.
REQ-011 DivZero  output  1  last result had D == 0.
REQ-012 Ovf  output  1  last result was X = -2^(N-1) with D = -1.

Function
REQ-013 The block SHALL compute Q = trunc(X/D) (rounding toward zero) and Rm = X - Q*D, with Rm taking the sign of X or being 0, and |Rm| < |D|.
REQ-014 Operation SHALL be one quotient bit per cycle (radix-2 restoring or non-restoring, unsigned core on magnitudes), no combinational divide operator.
REQ-015 States: IDLE, ITER, FIX. Ld in any state loads X, D, enters ITER, and sets Busy.
REQ-016 ITER SHALL last exactly N cycles; FIX (sign and remainder correction) SHALL last exactly 1 cycle, then return to IDLE.
REQ-017 Latency: Ld is sampled high at edge E0. Q/Rm/DivZero/Ovf SHALL register at edge E0+N+1. Valid SHALL be high for exactly the cycle following that edge.
REQ-018 Busy SHALL be high from the cycle after E0 through the cycle ending at edge E0+N+1. It SHALL be low while Valid is high, unless a new Ld arrived.
REQ-019 Q, Rm, DivZero and Ovf SHALL hold their last values until the next result edge. They SHALL NOT change during ITER.
REQ-020 Ld asserted while Busy SHALL abort the current division, restart with the new operands, and produce no Valid for the aborted one.
REQ-021 Ld asserted on the same edge as a result registers SHALL let that result and its Valid complete, and start the new division at that edge.
REQ-022 D == 0: the block SHALL still take N+1 cycles. Result: Q = all ones, Rm = X, DivZero = 1, Ovf = 0.
REQ-023 X = -2^(N-1), D = -1: Q = -2^(N-1) (wrapped), Rm = 0, Ovf = 1, DivZero = 0.
REQ-024 Magnitude datapath SHALL be N+1 bits wide so that |X| = 2^(N-1) is represented without overflow.
REQ-025 Flags SHALL be cleared on every non-exceptional result.
REQ-026 Operand inputs SHALL be ignored except on edges where Ld = 1.

Reset
REQ-027 Rst = 1 at an edge SHALL force IDLE. Busy, Valid, Q, Rm, DivZero and Ovf SHALL all be 0, and all internal counters and registers cleared.
REQ-028 Rst SHALL take priority over Ld.
REQ-029 Rst during ITER or FIX SHALL discard the operation, with no Valid pulse afterward.

Verification (N = 8)
REQ-030 Ld with X=100, D=7 -> Valid exactly 10 cycles after the Ld edge; Q=0x0E, Rm=0x02, flags 0.
REQ-031 Ld with X=-100 (0x9C), D=7 -> Q=0xF2 (-14), Rm=0xFE (-2). Repeat with D=-7 -> Q=0x0E, Rm=0xFE.
REQ-032 Ld with X=100, D=0 -> Q=0xFF, Rm=0x64, DivZero=1. Next Ld with X=9, D=3 -> Q=0x03, Rm=0, DivZero=0.
REQ-033 Ld with X=0x80, D=0xFF -> Q=0x80, Rm=0x00, Ovf=1. Also X=0x80, D=0x01 -> Q=0x80, Rm=0, Ovf=0.
REQ-034 Ld with X=50, D=5, then Ld at cycle 4 with X=17, D=4 -> a single Valid, 10 cycles after the second Ld; Q=0x04, Rm=0x01.
REQ-035 Rst pulsed at cycle 5 of a division -> all outputs 0 and no Valid. Then a random self-checking sweep of 10k operand pairs plus all corner values (0, ±1, 0x7F, 0x80) against a reference model.
